// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-state encoding and width/PC defaults for the IF fetch sequencer
package if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam int IF_DATA_W = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SQUASH,
        S_OUT
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_perf.sv
// rtl/if_fetch_perf.sv - saturating fetch/squash event counters (built only with IF_FETCH_PERF_EN)
`ifdef IF_FETCH_PERF_EN
module if_fetch_perf (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        squash_inc,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_squash
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch  <= '0;
            perf_squash <= '0;
        end else begin
            if (fetch_inc && (perf_fetch != '1))
                perf_fetch <= perf_fetch + 32'd1;
            if (squash_inc && (perf_squash != '1))
                perf_squash <= perf_squash + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - IF-stage fetch sequencer for a req/ready instruction memory
// Optional perf counters are built when IF_FETCH_PERF_EN is defined.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                DATA_W   = IF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(IF_PC_STEP)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              Branch_Tacken,
    input  logic [ADDR_W-1:0] Branch_Address,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] Instruction,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_squash
);

    fetch_state_t      state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] addr_step;
    logic              fetch_inc;
    logic              squash_inc;

    assign addr_step = addr_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            pc4_q  <= '0;
            inst_q <= '0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            addr_q <= addr_d;
            pc4_q  <= pc4_d;
            inst_q <= inst_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        addr_d     = addr_q;
        pc4_d      = pc4_q;
        inst_d     = inst_q;
        fetch_inc  = 1'b0;
        squash_inc = 1'b0;
        case (state)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = pc;
            end
            S_REQ: begin
                if (Branch_Tacken) begin
                    pc_d = Branch_Address;
                    if (mem_ready) begin
                        addr_d     = Branch_Address;
                        squash_inc = 1'b1;
                    end else begin
                        state_d = S_SQUASH;
                    end
                end else if (mem_ready) begin
                    state_d   = S_OUT;
                    inst_d    = mem_rdata;
                    pc4_d     = addr_step;
                    pc_d      = addr_step;
                    fetch_inc = 1'b1;
                end
            end
            // The memory cannot abort, so the stale response is awaited and dropped.
            S_SQUASH: begin
                if (Branch_Tacken)
                    pc_d = Branch_Address;
                if (mem_ready) begin
                    state_d    = S_REQ;
                    addr_d     = Branch_Tacken ? Branch_Address : pc;
                    squash_inc = 1'b1;
                end
            end
            S_OUT: begin
                if (Branch_Tacken) begin
                    state_d = S_REQ;
                    addr_d  = Branch_Address;
                    pc_d    = Branch_Address;
                end else if (!freeze) begin
                    state_d = S_REQ;
                    addr_d  = pc;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req     = (state == S_REQ) || (state == S_SQUASH);
    assign mem_addr    = addr_q;
    assign inst_valid  = (state == S_OUT);
    assign Instruction = inst_q;
    assign pc_plus4    = pc4_q;

`ifdef IF_FETCH_PERF_EN
    if_fetch_perf u_perf (
        .clk        (clk),
        .rst        (rst),
        .fetch_inc  (fetch_inc),
        .squash_inc (squash_inc),
        .perf_fetch (perf_fetch),
        .perf_squash(perf_squash)
    );
`else
    logic unused_perf;
    assign unused_perf = fetch_inc ^ squash_inc;
    assign perf_fetch  = '0;
    assign perf_squash = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed and randomized self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, freeze, Branch_Tacken, mem_ready;
    logic [31:0] Branch_Address, mem_rdata;
    logic        mem_req, inst_valid;
    logic [31:0] mem_addr, Instruction, pc_plus4, perf_fetch, perf_squash;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_fetch = 0;
    int exp_squash = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .Branch_Tacken (Branch_Tacken),
        .Branch_Address(Branch_Address),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .Instruction   (Instruction),
        .pc_plus4      (pc_plus4),
        .perf_fetch    (perf_fetch),
        .perf_squash   (perf_squash)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
    endfunction

    function automatic logic [31:0] perf_exp(input int n);
`ifdef IF_FETCH_PERF_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_seq(input logic [31:0] a);
        mem_ready = 1'b1;
        mem_rdata = mem_word(a);
        tick();
        mem_ready = 1'b0;
        exp_fetch++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; freeze = 1'b0; Branch_Tacken = 1'b0; Branch_Address = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        total_cnt++;
        if ({mem_req, mem_addr, inst_valid, Instruction, pc_plus4} !== 98'h0)
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b inst=%h pc4=%h want all 0",
                     mem_req, mem_addr, inst_valid, Instruction, pc_plus4);
        else pass_cnt++;
        total_cnt++;
        if ({perf_fetch, perf_squash} !== 64'h0)
            $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetch, perf_squash);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0})
            $display("FAIL first_req: got req=%b addr=%h want 1/00000000", mem_req, mem_addr);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] a;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = 32'(4 * k);
            total_cnt++;
            if ({mem_req, mem_addr} !== {1'b1, a})
                $display("FAIL stream_req%0d: got req=%b addr=%h want 1/%h", k, mem_req, mem_addr, a);
            else pass_cnt++;
            mem_rdata = mem_word(a);
            tick();
            exp_fetch++;
            total_cnt++;
            if ({inst_valid, mem_req, Instruction, pc_plus4} !== {1'b1, 1'b0, mem_word(a), a + 32'd4})
                $display("FAIL stream_out%0d: got v=%b req=%b inst=%h pc4=%h want 1/0/%h/%h",
                         k, inst_valid, mem_req, Instruction, pc_plus4, mem_word(a), a + 32'd4);
            else pass_cnt++;
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_wait();
        for (int w = 0; w < 4; w++) begin
            total_cnt++;
            if ({mem_req, mem_addr} !== {1'b1, 32'h10})
                $display("FAIL wait_hold%0d: got req=%b addr=%h want 1/00000010", w, mem_req, mem_addr);
            else pass_cnt++;
            if (w == 3) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(32'h10);
            end
            tick();
        end
        mem_ready = 1'b0;
        exp_fetch++;
        total_cnt++;
        if ({inst_valid, Instruction, pc_plus4} !== {1'b1, mem_word(32'h10), 32'h14})
            $display("FAIL wait_out: got v=%b inst=%h pc4=%h want 1/%h/00000014",
                     inst_valid, Instruction, pc_plus4, mem_word(32'h10));
        else pass_cnt++;
        tick();
    endtask

    task automatic test_squash();
        fetch_seq(32'h14); fetch_seq(32'h18); fetch_seq(32'h1C);
        tick();
        Branch_Tacken = 1'b1; Branch_Address = 32'h100;
        tick();
        Branch_Tacken = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total_cnt++;
            if ({mem_req, mem_addr, inst_valid} !== {1'b1, 32'h20, 1'b0})
                $display("FAIL squash_hold%0d: got req=%b addr=%h v=%b want 1/00000020/0",
                         c, mem_req, mem_addr, inst_valid);
            else pass_cnt++;
            if (c == 1) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(32'h20);
            end
            tick();
        end
        mem_ready = 1'b0;
        exp_squash++;
        total_cnt++;
        if ({mem_req, mem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0})
            $display("FAIL squash_redirect: got req=%b addr=%h v=%b want 1/00000100/0",
                     mem_req, mem_addr, inst_valid);
        else pass_cnt++;
        total_cnt++;
        if ({perf_fetch, perf_squash} !== {perf_exp(exp_fetch), perf_exp(exp_squash)})
            $display("FAIL squash_perf: got %0d/%0d want %0d/%0d", perf_fetch, perf_squash,
                     perf_exp(exp_fetch), perf_exp(exp_squash));
        else pass_cnt++;
        mem_ready = 1'b1; mem_rdata = mem_word(32'h100);
        tick();
        mem_ready = 1'b0;
        exp_fetch++;
        total_cnt++;
        if ({inst_valid, Instruction, pc_plus4} !== {1'b1, mem_word(32'h100), 32'h104})
            $display("FAIL squash_target: got v=%b inst=%h pc4=%h want 1/%h/00000104",
                     inst_valid, Instruction, pc_plus4, mem_word(32'h100));
        else pass_cnt++;
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            total_cnt++;
            if ({inst_valid, mem_req, Instruction, pc_plus4} !== {1'b1, 1'b0, mem_word(32'h100), 32'h104})
                $display("FAIL freeze_hold%0d: got v=%b req=%b inst=%h pc4=%h", c, inst_valid,
                         mem_req, Instruction, pc_plus4);
            else pass_cnt++;
        end
        freeze = 1'b0;
        tick();
        total_cnt++;
        if ({mem_req, mem_addr, inst_valid} !== {1'b1, 32'h104, 1'b0})
            $display("FAIL freeze_release: got req=%b addr=%h v=%b want 1/00000104/0",
                     mem_req, mem_addr, inst_valid);
        else pass_cnt++;
    endtask

    task automatic test_redirect();
        mem_ready = 1'b1; mem_rdata = mem_word(32'h104);
        tick();
        mem_ready = 1'b0; exp_fetch++;
        freeze = 1'b1; Branch_Tacken = 1'b1; Branch_Address = 32'h200;
        tick();
        freeze = 1'b0; Branch_Tacken = 1'b0;
        total_cnt++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL redirect_out: got v=%b req=%b addr=%h want 0/1/00000200",
                     inst_valid, mem_req, mem_addr);
        else pass_cnt++;
        mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        Branch_Tacken = 1'b1; Branch_Address = 32'h300;
        tick();
        mem_ready = 1'b0; Branch_Tacken = 1'b0; exp_squash++;
        total_cnt++;
        if ({inst_valid, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h300})
            $display("FAIL redirect_ready: got v=%b req=%b addr=%h want 0/1/00000300",
                     inst_valid, mem_req, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({perf_fetch, perf_squash} !== {perf_exp(exp_fetch), perf_exp(exp_squash)})
            $display("FAIL redirect_perf: got %0d/%0d want %0d/%0d", perf_fetch, perf_squash,
                     perf_exp(exp_fetch), perf_exp(exp_squash));
        else pass_cnt++;
        mem_ready = 1'b1; mem_rdata = mem_word(32'h300);
        tick();
        mem_ready = 1'b0; exp_fetch++;
        total_cnt++;
        if ({inst_valid, Instruction, pc_plus4} !== {1'b1, mem_word(32'h300), 32'h304})
            $display("FAIL redirect_target: got v=%b inst=%h pc4=%h want 1/%h/00000304",
                     inst_valid, Instruction, pc_plus4, mem_word(32'h300));
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_squash();
        Branch_Tacken = 1'b1; Branch_Address = 32'h400;
        tick();
        Branch_Tacken = 1'b0;
        rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        exp_fetch = 0; exp_squash = 0;
        total_cnt++;
        if ({mem_req, mem_addr, inst_valid, Instruction, pc_plus4, perf_fetch, perf_squash} !== 162'h0)
            $display("FAIL rst_squash: got req=%b addr=%h v=%b inst=%h pc4=%h perf=%0d/%0d want all 0",
                     mem_req, mem_addr, inst_valid, Instruction, pc_plus4, perf_fetch, perf_squash);
        else pass_cnt++;
        rst = 1'b0; Branch_Tacken = 1'b1; Branch_Address = 32'h500;
        tick();
        Branch_Tacken = 1'b0; mem_ready = 1'b0;
        total_cnt++;
        if ({mem_req, mem_addr, inst_valid, Instruction} !== {1'b1, 32'h0, 1'b0, 32'h0})
            $display("FAIL rst_first_req: got req=%b addr=%h v=%b inst=%h want 1/0/0/0",
                     mem_req, mem_addr, inst_valid, Instruction);
        else pass_cnt++;
        fetch_seq(32'h0);
    endtask

    task automatic test_wrap();
        Branch_Tacken = 1'b1; Branch_Address = 32'hFFFF_FFFC;
        tick();
        Branch_Tacken = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        exp_squash++;
        total_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", mem_req, mem_addr);
        else pass_cnt++;
        mem_rdata = mem_word(32'hFFFF_FFFC);
        tick();
        mem_ready = 1'b0; exp_fetch++;
        total_cnt++;
        if ({inst_valid, Instruction, pc_plus4} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'h0})
            $display("FAIL wrap_out: got v=%b inst=%h pc4=%h want 1/%h/00000000",
                     inst_valid, Instruction, pc_plus4, mem_word(32'hFFFF_FFFC));
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h0})
            $display("FAIL wrap_next: got req=%b addr=%h want 1/00000000", mem_req, mem_addr);
        else pass_cnt++;
        total_cnt++;
        if ({perf_fetch, perf_squash} !== {perf_exp(exp_fetch), perf_exp(exp_squash)})
            $display("FAIL wrap_perf: got %0d/%0d want %0d/%0d", perf_fetch, perf_squash,
                     perf_exp(exp_fetch), perf_exp(exp_squash));
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, prev_addr, prev_inst, prev_pc4;
        logic        hold_req, frozen;
        int          delivered, flushed, handshakes, slot_fills;
        rst = 1'b1; freeze = 1'b0; Branch_Tacken = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        exp_pc = 32'h0; delivered = 0; flushed = 0; handshakes = 0;
        hold_req = 1'b0; frozen = 1'b0; prev_addr = '0; prev_inst = '0; prev_pc4 = '0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_req) begin
                total_cnt++;
                if ({mem_req, mem_addr} !== {1'b1, prev_addr})
                    $display("FAIL rnd_req_stable@%0d: got req=%b addr=%h want 1/%h", i, mem_req, mem_addr, prev_addr);
                else pass_cnt++;
            end
            if (frozen) begin
                total_cnt++;
                if ({inst_valid, Instruction, pc_plus4} !== {1'b1, prev_inst, prev_pc4})
                    $display("FAIL rnd_freeze@%0d: got v=%b inst=%h pc4=%h want 1/%h/%h", i,
                             inst_valid, Instruction, pc_plus4, prev_inst, prev_pc4);
                else pass_cnt++;
            end
            total_cnt++;
            if ((mem_req & inst_valid) !== 1'b0)
                $display("FAIL rnd_req_while_full@%0d: got req=%b v=%b want not both", i, mem_req, inst_valid);
            else pass_cnt++;

            Branch_Tacken  = (i >= 2) && ($urandom_range(0, 99) < 7);
            Branch_Address = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                          : 32'($urandom_range(0, 1023)) << 2;
            freeze    = $urandom_range(0, 99) < 35;
            mem_ready = mem_req && ($urandom_range(0, 99) < 45);
            mem_rdata = mem_ready ? mem_word(mem_addr) : 32'($urandom);

            if (Branch_Tacken) begin
                if (inst_valid) flushed++;
                exp_pc = Branch_Address;
            end else if (inst_valid && !freeze) begin
                total_cnt++;
                if ({Instruction, pc_plus4} !== {mem_word(exp_pc), exp_pc + 32'd4})
                    $display("FAIL rnd_deliver@%0d: got inst=%h pc4=%h want %h/%h", i,
                             Instruction, pc_plus4, mem_word(exp_pc), exp_pc + 32'd4);
                else pass_cnt++;
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (mem_req && mem_ready) handshakes++;
            hold_req  = mem_req && !mem_ready;
            prev_addr = mem_addr;
            frozen    = inst_valid && freeze && !Branch_Tacken;
            prev_inst = Instruction;
            prev_pc4  = pc_plus4;
            tick();
        end
        Branch_Tacken = 1'b0; freeze = 1'b1; mem_ready = 1'b0;
        total_cnt++;
        if (delivered < 100)
            $display("FAIL rnd_progress: got %0d deliveries want >= 100", delivered);
        else pass_cnt++;
        slot_fills = delivered + flushed + (inst_valid ? 1 : 0);
        total_cnt++;
        if ({perf_fetch, perf_squash} !== {perf_exp(slot_fills), perf_exp(handshakes - slot_fills)})
            $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", perf_fetch, perf_squash,
                     perf_exp(slot_fills), perf_exp(handshakes - slot_fills));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_wait();
        test_squash();
        test_freeze();
        test_redirect();
        test_reset_squash();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
